mmio_peripheral: RTL and testbench



---
 rtl/mmio_peripheral_if.sv | 25 ++
 rtl/mmio_peripheral.sv | 131 +++++++++++++
 tb/tb_mmio_peripheral.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mmio_peripheral_if.sv
// CPU-side memory bus seen by the MMIO peripheral: EX/MEM address,
// store data and strobes in, combinational load data out.
interface mmio_peripheral_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;

  modport master (
    output Address,
    output Write_data,
    output MemRead,
    output MemWrite,
    input  Read_data
  );

  modport slave (
    input  Address,
    input  Write_data,
    input  MemRead,
    input  MemWrite,
    output Read_data
  );
endinterface

// File: rtl/mmio_peripheral.sv
// Memory-mapped peripheral: reloadable interval timer with interrupt,
// LED and 7-segment registers, switch input and a free-running cycle
// counter. Loads are combinational; stores land on the rising edge.
module mmio_peripheral #(
  parameter logic [31:0] BASE_ADDR  = 32'h40000000,
  parameter int          LED_WIDTH  = 8,
  parameter int          DIGI_WIDTH = 12
) (
  input  logic                  sysclk,
  input  logic                  reset,
  mmio_peripheral_if.slave      bus,
  input  logic [7:0]            switch,
  output logic [LED_WIDTH-1:0]  led,
  output logic [DIGI_WIDTH-1:0] digi,
  output logic                  irqout
);

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_SWITCH  = 3'd4;
  localparam logic [2:0] OFF_DIGI    = 3'd5;
  localparam logic [2:0] OFF_SYSTICK = 3'd6;

  logic [31:0]           th_q, th_d;
  logic [31:0]           tl_q, tl_d;
  logic [2:0]            tcon_q, tcon_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic [DIGI_WIDTH-1:0] digi_q, digi_d;
  logic [31:0]           systick_q, systick_d;

  logic [2:0]  offset_s;
  logic        hit_s;
  logic        wr_en_s;
  logic [31:0] rdata_s;
  logic        unused_s;

  assign offset_s = bus.Address[4:2];
  assign unused_s = ^bus.Address[1:0];

  // Address decode: window match on the upper bits, and offset 7 is unmapped.
  always_comb begin
    hit_s   = (bus.Address[31:5] == BASE_ADDR[31:5]) && (offset_s != 3'd7);
    wr_en_s = bus.MemWrite && hit_s;
  end

  // Combinational load data from current register state (pre-write value).
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (bus.MemRead && hit_s) begin
      case (offset_s)
        OFF_TH:      rdata_s = th_q;
        OFF_TL:      rdata_s = tl_q;
        OFF_TCON:    rdata_s = {29'd0, tcon_q};
        OFF_LED:     rdata_s = {{(32-LED_WIDTH){1'b0}}, led_q};
        OFF_SWITCH:  rdata_s = {24'd0, switch};
        OFF_DIGI:    rdata_s = {{(32-DIGI_WIDTH){1'b0}}, digi_q};
        OFF_SYSTICK: rdata_s = systick_q;
        default:     rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.Read_data = rdata_s;

  // Next state: timer step first, then CPU stores override the fields they hit.
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;

    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        // Reload always takes the TH held before this edge.
        tl_d = th_q;
        if (tcon_q[1]) begin
          tcon_d[2] = 1'b1;
        end else begin
          tcon_d[2] = tcon_q[2];
        end
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end else begin
      tl_d = tl_q;
    end

    if (wr_en_s) begin
      case (offset_s)
        OFF_TH:   th_d   = bus.Write_data;
        OFF_TL:   tl_d   = bus.Write_data;
        OFF_TCON: tcon_d = bus.Write_data[2:0];
        OFF_LED:  led_d  = bus.Write_data[LED_WIDTH-1:0];
        OFF_DIGI: digi_d = bus.Write_data[DIGI_WIDTH-1:0];
        default:  ;  // SWITCH and SYSTICK are read-only
      endcase
    end else begin
      th_d = th_d;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      th_q      <= 32'h0000_0000;
      tl_q      <= 32'h0000_0000;
      tcon_q    <= 3'b000;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= 32'h0000_0000;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
    end
  end

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[2];

endmodule

// File: tb/tb_mmio_peripheral.sv
// Self-checking bench for mmio_peripheral: register-map vector table plus
// hand-written timer, reset and systick sequences.
module tb_mmio_peripheral;

  localparam logic [31:0] A_TH      = 32'h40000000;
  localparam logic [31:0] A_TL      = 32'h40000004;
  localparam logic [31:0] A_TCON    = 32'h40000008;
  localparam logic [31:0] A_LED     = 32'h4000000C;
  localparam logic [31:0] A_SWITCH  = 32'h40000010;
  localparam logic [31:0] A_DIGI    = 32'h40000014;
  localparam logic [31:0] A_SYSTICK = 32'h40000018;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] switch = 8'h00;
  logic [7:0] led;
  logic [11:0] digi;
  logic       irqout;

  mmio_peripheral_if bus ();

  mmio_peripheral #(
    .BASE_ADDR (32'h40000000),
    .LED_WIDTH (8),
    .DIGI_WIDTH(12)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus),
    .switch(switch),
    .led   (led),
    .digi  (digi),
    .irqout(irqout)
  );

  always #5 sysclk = ~sysclk;

  // Reference cycle counter for SYSTICK.
  int unsigned tick_m = 0;
  always @(posedge sysclk) begin
    if (reset) tick_m <= 0;
    else       tick_m <= tick_m + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.Address    = addr;
    bus.Write_data = data;
    bus.MemWrite   = 1'b1;
    bus.MemRead    = 1'b0;
    cyc();
    bus.MemWrite   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    bus.Address = addr;
    bus.MemRead = 1'b1;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    chk(nm, bus.Read_data, e);
    bus.MemRead = 1'b0;
  endtask

  initial begin
    bus.Address    = 32'h0;
    bus.Write_data = 32'h0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;

    // Reset state
    repeat (2) @(posedge sysclk);
    #1;
    chk("rst_led", {24'd0, led}, 32'h0);
    chk("rst_digi", {20'd0, digi}, 32'h0);
    chk("rst_irq", {31'd0, irqout}, 32'h0);
    chk("rst_rdata", bus.Read_data, 32'h0);
    reset = 1'b0;
    cyc();
    cyc();
    rd(A_SYSTICK, 32'd2, "systick_after_reset");

    // Interval timer with interrupt
    wr(A_TH, 32'hFFFFFFFC);
    wr(A_TL, 32'hFFFFFFFC);
    wr(A_TCON, 32'h3);
    rd(A_TL, 32'hFFFFFFFC, "tl_start");
    cyc(); rd(A_TL, 32'hFFFFFFFD, "tl_step1");
    cyc(); rd(A_TL, 32'hFFFFFFFE, "tl_step2");
    cyc(); rd(A_TL, 32'hFFFFFFFF, "tl_step3");
    chk("irq_before_reload", {31'd0, irqout}, 32'h0);
    cyc(); rd(A_TL, 32'hFFFFFFFC, "tl_reload");
    rd(A_TCON, 32'h7, "tcon_reload");
    chk("irq_set", {31'd0, irqout}, 32'h1);
    wr(A_TCON, 32'h3);
    chk("irq_cleared", {31'd0, irqout}, 32'h0);
    rd(A_TCON, 32'h3, "tcon_cleared");
    rd(A_TL, 32'hFFFFFFFD, "tl_continue1");
    cyc(); rd(A_TL, 32'hFFFFFFFE, "tl_continue2");
    wr(A_TCON, 32'h0);

    // Reload with interrupt disabled
    wr(A_TH, 32'h10);
    wr(A_TL, 32'hFFFFFFFF);
    wr(A_TCON, 32'h1);
    cyc();
    rd(A_TL, 32'h10, "noirq_reload_tl");
    rd(A_TCON, 32'h1, "noirq_tcon");
    chk("noirq_irq", {31'd0, irqout}, 32'h0);
    wr(A_TCON, 32'h0);

    // CPU write to TL in the overflow cycle
    wr(A_TH, 32'h0);
    wr(A_TL, 32'hFFFFFFFE);
    wr(A_TCON, 32'h3);
    cyc();
    wr(A_TL, 32'h5);
    rd(A_TL, 32'h5, "ovf_write_tl");
    rd(A_TCON, 32'h7, "ovf_write_tcon");
    chk("ovf_write_irq", {31'd0, irqout}, 32'h1);
    wr(A_TCON, 32'h0);
    chk("ovf_irq_cleared", {31'd0, irqout}, 32'h0);

    // CPU write to TH in the reload cycle
    wr(A_TH, 32'h20);
    wr(A_TL, 32'hFFFFFFFF);
    wr(A_TCON, 32'h1);
    wr(A_TH, 32'h30);
    rd(A_TL, 32'h20, "th_wr_reload_tl");
    rd(A_TH, 32'h30, "th_wr_reload_th");
    wr(A_TCON, 32'h0);

    // Register-map vectors
    switch = 8'h3C;
    tbl[0]  = '{1'b1, 1'b0, A_TCON,       32'h0,     32'h0,        "tcon_off"};
    tbl[1]  = '{1'b1, 1'b0, A_LED,        32'h1A5,   32'h0,        "wr_led"};
    tbl[2]  = '{1'b0, 1'b1, A_LED,        32'h0,     32'h000000A5, "rd_led"};
    tbl[3]  = '{1'b1, 1'b0, A_DIGI,       32'hF7E,   32'h0,        "wr_digi"};
    tbl[4]  = '{1'b0, 1'b1, A_DIGI,       32'h0,     32'h00000F7E, "rd_digi"};
    tbl[5]  = '{1'b0, 1'b1, A_SWITCH,     32'h0,     32'h0000003C, "rd_switch"};
    tbl[6]  = '{1'b0, 1'b1, 32'h40000020, 32'h0,     32'h0,        "rd_miss_above"};
    tbl[7]  = '{1'b0, 1'b1, 32'h10000004, 32'h0,     32'h0,        "rd_miss_base"};
    tbl[8]  = '{1'b1, 1'b0, A_TL,         32'h55,    32'h0,        "wr_tl"};
    tbl[9]  = '{1'b1, 1'b0, 32'h10000004, 32'h1234,  32'h0,        "wr_miss"};
    tbl[10] = '{1'b0, 1'b1, A_TL,         32'h0,     32'h00000055, "rd_tl_after_miss"};
    tbl[11] = '{1'b0, 1'b1, 32'h4000001C, 32'h0,     32'h0,        "rd_offset7"};
    tbl[12] = '{1'b1, 1'b1, A_LED,        32'h13C,   32'h000000A5, "rdwr_led_prewrite"};
    for (int i = 0; i < 13; i++) begin
      bus.Address    = tbl[i].addr;
      bus.Write_data = tbl[i].wdata;
      bus.MemWrite   = tbl[i].we;
      bus.MemRead    = tbl[i].re;
      if (tbl[i].re) exp_q.push_back(tbl[i].exp);
      #1;
      if (tbl[i].re) chk(tbl[i].name, bus.Read_data, exp_q.pop_front());
      cyc();
      bus.MemWrite = 1'b0;
      bus.MemRead  = 1'b0;
    end
    chk("led_port", {24'd0, led}, 32'h3C);
    chk("digi_port", {20'd0, digi}, 32'hF7E);
    rd(A_LED, 32'h3C, "rd_led_after_rdwr");
    rd(32'h4000000B, 32'h0, "rd_tcon_low_bits");

    // SYSTICK is read-only
    wr(A_SYSTICK, 32'h0);
    rd(A_SYSTICK, tick_m, "systick_wr_ignored");

    // Reset asserted mid-count clears state without a clock edge
    wr(A_TH, 32'h0);
    wr(A_TL, 32'hFFFFFFFF);
    wr(A_TCON, 32'h3);
    cyc();
    chk("pre_reset_irq", {31'd0, irqout}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_irq", {31'd0, irqout}, 32'h0);
    rd(A_TCON, 32'h0, "async_rst_tcon");
    rd(A_TL, 32'h0, "async_rst_tl");
    rd(A_SYSTICK, 32'h0, "async_rst_systick");
    chk("async_rst_led", {24'd0, led}, 32'h0);
    cyc();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
